// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, owner
// encoding and the legal BRAM read-latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 3;

    function automatic bit mem_lat_legal(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port
// synchronous BRAM, returning per-port ready pulses and a global pipeline stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall
);

    // An out-of-range latency saturates to the nearest legal value so the
    // 2-bit counter can always reach its terminal count.
    localparam int         LAT_EFF = mem_lat_legal(MEM_LAT) ? MEM_LAT :
                                     (MEM_LAT < MEM_LAT_MIN ? MEM_LAT_MIN : MEM_LAT_MAX);
    localparam logic [1:0] LAT_END = 2'(LAT_EFF);
    localparam logic [1:0] RUN_MAX = 2'(MAX_DATA_RUN);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [1:0]  run_cnt_q, run_cnt_d;
    logic        if_ready_d, d_ready_d;
    logic        if_cap, d_cap;
    logic        grant_data, grant_if;

    // Data wins ties until it has taken MAX_DATA_RUN grants in a row over a waiting fetch.
    assign grant_data = d_req & (~if_req | (run_cnt_q < RUN_MAX));
    assign grant_if   = if_req & ~grant_data;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        run_cnt_d  = run_cnt_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        if_cap     = 1'b0;
        d_cap      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = (owner_q == OWN_IF) ? if_addr : d_addr;
        mem_wdata  = d_wdata;

        unique case (state_q)
            IDLE: begin
                // A request seen in its own ready cycle is the one just served, not a new one.
                if (!rst && !if_ready && !d_ready) begin
                    if (grant_data) begin
                        mem_en    = 1'b1;
                        mem_addr  = d_addr;
                        owner_d   = OWN_DATA;
                        run_cnt_d = !if_req ? 2'd0 :
                                    (run_cnt_q == 2'd3) ? 2'd3 : run_cnt_q + 2'd1;
                        if (d_we) begin
                            mem_we    = d_be;
                            state_d   = WR_DONE;
                            d_ready_d = 1'b1;
                        end else begin
                            state_d   = RD_WAIT;
                            lat_cnt_d = 2'd1;
                        end
                    end else if (grant_if) begin
                        mem_en    = 1'b1;
                        mem_addr  = if_addr;
                        owner_d   = OWN_IF;
                        run_cnt_d = 2'd0;
                        state_d   = RD_WAIT;
                        lat_cnt_d = 2'd1;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == LAT_END) begin
                    state_d   = IDLE;
                    lat_cnt_d = 2'd0;
                    if (owner_q == OWN_IF) begin
                        if_cap     = 1'b1;
                        if_ready_d = 1'b1;
                    end else begin
                        d_cap     = 1'b1;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            lat_cnt_q <= 2'd0;
            run_cnt_q <= 2'd0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            run_cnt_q <= run_cnt_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            if (if_cap) if_rdata <= mem_rdata;
            if (d_cap)  d_rdata  <= mem_rdata;
        end
    end

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at
// MEM_LAT=3, each attached to a small behavioural BRAM.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Instance A: MEM_LAT = 1
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [13:0] if_addr = '0, d_addr = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_en, stall;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;

    // Instance B: MEM_LAT = 3
    logic        if_req_b = 1'b0, d_req_b = 1'b0, d_we_b = 1'b0;
    logic [13:0] if_addr_b = '0, d_addr_b = '0;
    logic [3:0]  d_be_b = '0;
    logic [31:0] d_wdata_b = '0;
    logic [31:0] if_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
    logic        if_ready_b, d_ready_b, mem_en_b, stall_b;
    logic [3:0]  mem_we_b;
    logic [13:0] mem_addr_b;

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_RUN(2)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(3), .MAX_DATA_RUN(2)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_be(d_be_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_rdata(d_rdata_b), .d_ready(d_ready_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .stall(stall_b)
    );

    // Behavioural BRAMs, preloaded while reset is held.
    logic [31:0] mem_a [128];
    logic [31:0] rd_a;
    assign mem_rdata = rd_a;

    always @(posedge clk) begin
        if (rst) begin
            mem_a[7'h10] <= 32'h0050_0093;
            mem_a[7'h20] <= 32'h1122_3344;
            rd_a         <= '0;
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem_a[mem_addr[6:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            rd_a <= mem_a[mem_addr[6:0]];
        end
    end

    logic [31:0] mem_b [128];
    logic [31:0] rd_b1, rd_b2, rd_b3;
    assign mem_rdata_b = rd_b3;

    always @(posedge clk) begin
        if (rst) begin
            mem_b[7'h40] <= 32'hCAFE_F00D;
        end else if (mem_en_b) begin
            for (int i = 0; i < 4; i++)
                if (mem_we_b[i]) mem_b[mem_addr_b[6:0]][8*i +: 8] <= mem_wdata_b[8*i +: 8];
        end
        rd_b1 <= mem_b[mem_addr_b[6:0]];
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int         ng;
    logic [3:0] order;

    initial begin
        // Reset state, with a fetch request present during reset
        next_cycle();
        next_cycle();
        if_req  = 1'b1;
        if_addr = 14'h0010;
        settle();
        check("rst_stall",    stall,    1);
        check("rst_mem_en",   mem_en,   0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_if_ready", if_ready, 0);
        check("rst_d_ready",  d_ready,  0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata",  d_rdata,  0);
        if_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Fetch only: grant T, ready + data T+2, stall low T+3
        if_req  = 1'b1;
        if_addr = 14'h0010;
        settle();
        check("f_mem_en",   mem_en,   1);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_mem_we",   mem_we,   0);
        check("f_stall_t",  stall,    1);
        next_cycle();
        check("f_en_wait",  mem_en,   0);
        check("f_rdy_t1",   if_ready, 0);
        next_cycle();
        check("f_rdy_t2",   if_ready, 1);
        check("f_rdata",    if_rdata, 32'h0050_0093);
        check("f_stall_t2", stall,    0);
        next_cycle();
        if_req = 1'b0;
        settle();
        check("f_stall_t3", stall,    0);
        check("f_rdy_t3",   if_ready, 0);
        check("f_hold",     if_rdata, 32'h0050_0093);

        // Partial store, then read back
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 14'h0020;
        d_wdata = 32'hAABB_CCDD;
        settle();
        check("s_mem_en",    mem_en,    1);
        check("s_mem_we",    mem_we,    4'b0011);
        check("s_mem_addr",  mem_addr,  32'h20);
        check("s_mem_wdata", mem_wdata, 32'hAABB_CCDD);
        next_cycle();
        check("s_ready",     d_ready,   1);
        check("s_en_done",   mem_en,    0);
        check("s_stall",     stall,     0);
        next_cycle();
        d_we = 1'b0;
        d_be = 4'b0000;
        settle();
        check("l_mem_en",    mem_en,    1);
        check("l_mem_we",    mem_we,    0);
        check("l_rdy_t0",    d_ready,   0);
        next_cycle();
        next_cycle();
        check("l_ready",     d_ready,   1);
        check("l_rdata",     d_rdata,   32'h1122_CCDD);
        next_cycle();
        d_req = 1'b0;

        // Simultaneous fetch and load: data first, fetch right after
        if_req  = 1'b1;
        if_addr = 14'h0010;
        d_req   = 1'b1;
        d_addr  = 14'h0020;
        settle();
        check("b_grant_d",   mem_addr,  32'h20);
        check("b_stall0",    stall,     1);
        next_cycle();
        next_cycle();
        check("b_d_ready",   d_ready,   1);
        check("b_if_wait",   if_ready,  0);
        check("b_stall_mid", stall,     1);
        check("b_no_grant",  mem_en,    0);
        next_cycle();
        d_req = 1'b0;
        settle();
        check("b_grant_if",  mem_en,    1);
        check("b_if_addr",   mem_addr,  32'h10);
        next_cycle();
        next_cycle();
        check("b_if_ready",  if_ready,  1);
        check("b_stall_end", stall,     0);
        next_cycle();
        if_req = 1'b0;

        // Continuous stores with a waiting fetch: D, D, IF, D
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b1111;
        d_addr  = 14'h0030;
        d_wdata = 32'h0;
        if_req  = 1'b1;
        if_addr = 14'h0010;
        ng      = 0;
        order   = 4'b0000;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            if (c > 0) next_cycle();
            else settle();
            if (mem_en) begin
                order[ng] = (mem_addr == 14'h0030);
                ng++;
            end
        end
        check("run_grants", ng,    4);
        check("run_order",  order, 4'b1011);
        next_cycle();
        next_cycle();
        d_req  = 1'b0;
        d_we   = 1'b0;
        if_req = 1'b0;
        settle();
        check("run_d_hold", d_rdata, 32'h1122_CCDD);
        check("run_idle",   stall,   0);

        // MEM_LAT = 3 load on instance B
        d_req_b  = 1'b1;
        d_addr_b = 14'h0040;
        settle();
        check("l3_mem_en", mem_en_b, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            check("l3_en_wait",  mem_en_b,  0);
            check("l3_rdy_wait", d_ready_b, 0);
        end
        next_cycle();
        check("l3_ready", d_ready_b, 1);
        check("l3_rdata", d_rdata_b, 32'hCAFE_F00D);
        next_cycle();
        d_req_b = 1'b0;

        // Reset during RD_WAIT on instance A
        if_req  = 1'b1;
        if_addr = 14'h0010;
        settle();
        check("r_grant",    mem_en,   1);
        next_cycle();
        rst = 1'b1;
        settle();
        check("r_wait_en",  mem_en,   0);
        next_cycle();
        check("r_if_ready", if_ready, 0);
        check("r_d_ready",  d_ready,  0);
        check("r_if_rdata", if_rdata, 0);
        check("r_d_rdata",  d_rdata,  0);
        check("r_mem_en",   mem_en,   0);
        check("r_stall",    stall,    1);
        next_cycle();
        rst = 1'b0;
        settle();
        check("r_regrant",  mem_en,   1);
        check("r_addr",     mem_addr, 32'h10);
        next_cycle();
        next_cycle();
        check("r_ready",    if_ready, 1);
        check("r_rdata",    if_rdata, 32'h0050_0093);
        next_cycle();
        if_req = 1'b0;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
